stream_byte_reverser: RTL and testbench

Byte-serial string reverser: accepts a string of bytes on a valid/ready input stream terminated by `s_last`, buffers it in an internal LIFO, then emits the bytes in reverse order on a valid/ready output stream. It is the streaming, variable-length counterpart of the team's fixed-width 32-bit combinational byte-swap datapath. It sits between a byte-stream producer (e.g. a UART receive path) and any consumer that needs reversed strings longer than one word.

---
 rtl/stream_byte_reverser_pkg.sv | 26 ++
 rtl/stream_byte_reverser_if.sv | 33 +++
 rtl/stream_byte_reverser_lifo_buffer.sv | 67 ++++++
 rtl/stream_byte_reverser.sv | 113 +++++++++++
 tb/tb_stream_byte_reverser.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_byte_reverser_pkg.sv
// ============================================================================
// Package : stream_rev_pkg
// Shared state encoding and default sizing for the stream byte reverser.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package stream_rev_pkg;

  // FILL collects a string, DRAIN replays it newest-first
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int c_default_data_w = 8;
  localparam int c_default_depth  = 32;

  // Width of a counter that must represent 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_byte_reverser_if.sv
// ============================================================================
// Interface : stream_byte_reverser_if
// Byte stream with valid/ready handshake and an end-of-string marker.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface stream_byte_reverser_if #(
  parameter int DATA_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

`default_nettype wire

// File: rtl/stream_byte_reverser_lifo_buffer.sv
// ============================================================================
// Module : lifo_buffer
// Stack of DATA_W words with a combinational top-of-stack read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lifo_buffer
  import stream_rev_pkg::*;
#(
  parameter int DATA_W = c_default_data_w,
  parameter int DEPTH  = c_default_depth
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        push,
  input  wire logic                        pop,
  input  wire logic [DATA_W-1:0]           wdata,
  output logic      [DATA_W-1:0]           rdata,
  output logic      [count_width(DEPTH)-1:0] count,
  output logic                             full,
  output logic                             empty
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign w_wr_idx  = AW'(r_count);
  assign w_rd_idx  = AW'(r_count - 1'b1);
  assign count     = r_count;

  // Index wraps when empty; the caller masks rdata in that case
  assign rdata = r_mem[w_rd_idx];

  // Storage is deliberately not reset; only the counter defines contents
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_byte_reverser.sv
// ============================================================================
// Module : stream_byte_reverser
// Buffers a last-terminated byte string and replays it in reverse order.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stream_byte_reverser
  import stream_rev_pkg::*;
#(
  parameter int DATA_W = c_default_data_w,
  parameter int DEPTH  = c_default_depth
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  stream_byte_reverser_if.slave   s,
  stream_byte_reverser_if.master  m,
  output logic                    overflow
);

  localparam int CW = count_width(DEPTH);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_s_ready;
  logic              w_m_valid;
  logic              w_s_hs;
  logic              w_m_hs;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_rdata;
  logic [CW-1:0]     w_count;
  logic              r_overflow;

  lifo_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (s.data),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_s_hs = s.valid && w_s_ready;
  assign w_m_hs = w_m_valid && m.ready;
  assign w_last = (w_count == CW'(1));
  // Bytes beyond DEPTH are accepted but dropped
  assign w_push = w_s_hs && !w_full;
  assign w_pop  = w_m_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake readiness depends on the state register only
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_m_valid   = 1'b0;
    case (r_state)
      FILL: begin
        w_s_ready = 1'b1;
        if (w_s_hs && s.last) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_m_valid = 1'b1;
        if (w_m_hs && w_last) begin
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // Sticky until the first byte of the following string is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_s_hs) begin
      if (w_full) begin
        r_overflow <= 1'b1;
      end else if (w_empty) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign s.ready  = w_s_ready;
  assign m.valid  = w_m_valid;
  assign m.data   = w_m_valid ? w_rdata : '0;
  assign m.last   = w_m_valid && w_last;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_stream_byte_reverser.sv
// ============================================================================
// Module : tb_stream_byte_reverser
// Self-checking bench for stream_byte_reverser (DEPTH=4 to reach overflow).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_stream_byte_reverser;

  localparam int DEPTH = 4;

  typedef struct {
    bit         sv;
    logic [7:0] sd;
    bit         sl;
    bit         mr;
    bit         e_sr;
    bit         e_mv;
    logic [7:0] e_md;
    bit         e_ml;
    bit         e_ov;
  } vec_t;

  logic clk;
  logic rst_n;
  logic overflow;

  stream_byte_reverser_if #(.DATA_W(8)) s_if ();
  stream_byte_reverser_if #(.DATA_W(8)) m_if ();

  stream_byte_reverser #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s_if),
    .m        (m_if),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the string as a queue, replayed from the back
  logic [7:0] mdl_q[$];
  bit         mdl_drain = 1'b0;
  bit         mdl_ovf   = 1'b0;
  bit         mdl_first = 1'b1;

  vec_t       tab[$];
  logic [7:0] got[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    mdl_q.delete();
    mdl_drain = 1'b0;
    mdl_ovf   = 1'b0;
    mdl_first = 1'b1;
  endtask

  task automatic add(input bit sv, input logic [7:0] sd, input bit sl, input bit mr,
                     input bit sr, input bit mv, input logic [7:0] md, input bit ml,
                     input bit ov);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.e_sr = sr; v.e_mv = mv; v.e_md = md; v.e_ml = ml; v.e_ov = ov;
    tab.push_back(v);
  endtask

  // One clock: drive, compare against model (and table row if given), update model
  task automatic cycle(input vec_t v, input bit use_tab, output bit out_acc,
                       output logic [7:0] out_d);
    logic [7:0] e_md;
    @(negedge clk);
    s_if.valid = v.sv;
    s_if.data  = v.sd;
    s_if.last  = v.sl;
    m_if.ready = v.mr;
    #1;
    e_md = mdl_drain ? mdl_q[$] : 8'h00;
    chk("s_ready", {7'd0, s_if.ready}, {7'd0, !mdl_drain});
    chk("m_valid", {7'd0, m_if.valid}, {7'd0, mdl_drain});
    chk("m_data", m_if.data, e_md);
    chk("m_last", {7'd0, m_if.last}, {7'd0, mdl_drain && mdl_q.size() == 1});
    chk("overflow", {7'd0, overflow}, {7'd0, mdl_ovf});
    if (use_tab) begin
      chk("tab_s_ready", {7'd0, s_if.ready}, {7'd0, v.e_sr});
      chk("tab_m_valid", {7'd0, m_if.valid}, {7'd0, v.e_mv});
      chk("tab_m_data", m_if.data, v.e_md);
      chk("tab_m_last", {7'd0, m_if.last}, {7'd0, v.e_ml});
      chk("tab_overflow", {7'd0, overflow}, {7'd0, v.e_ov});
    end
    out_d   = m_if.data;
    out_acc = mdl_drain && v.mr;
    @(posedge clk);
    if (!mdl_drain && v.sv) begin
      if (mdl_first) begin
        mdl_ovf   = 1'b0;
        mdl_first = 1'b0;
      end
      if (mdl_q.size() < DEPTH) mdl_q.push_back(v.sd);
      else                      mdl_ovf = 1'b1;
      if (v.sl) mdl_drain = 1'b1;
    end else if (mdl_drain && v.mr) begin
      void'(mdl_q.pop_back());
      if (mdl_q.size() == 0) begin
        mdl_drain = 1'b0;
        mdl_first = 1'b1;
      end
    end
  endtask

  task automatic step(input bit sv, input logic [7:0] sd, input bit sl, input bit mr);
    vec_t v;
    bit acc;
    logic [7:0] d;
    v = '{sv: sv, sd: sd, sl: sl, mr: mr, e_sr: 0, e_mv: 0, e_md: 0, e_ml: 0, e_ov: 0};
    cycle(v, 1'b0, acc, d);
    if (acc) got.push_back(d);
  endtask

  task automatic chk_got(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, 8'(got.size()), 8'(exp.size()));
    foreach (exp[i]) begin
      if (i < got.size()) chk(name, got[i], exp[i]);
    end
    got.delete();
  endtask

  initial begin
    bit         acc;
    logic [7:0] d;
    logic [7:0] src_d[5];
    bit         src_l[5];
    int         idx;

    rst_n      = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    s_if.last  = 1'b0;
    m_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", {7'd0, s_if.ready}, 8'd1);
    chk("rst_m_valid", {7'd0, m_if.valid}, 8'd0);
    chk("rst_m_data", m_if.data, 8'h00);
    chk("rst_m_last", {7'd0, m_if.last}, 8'd0);
    chk("rst_overflow", {7'd0, overflow}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // sv sd sl mr | s_ready m_valid m_data m_last overflow
    add(1, 8'hDE, 0, 1, 1, 0, 8'h00, 0, 0);
    add(1, 8'hAD, 0, 1, 1, 0, 8'h00, 0, 0);
    add(1, 8'hBE, 0, 1, 1, 0, 8'h00, 0, 0);
    add(1, 8'hEF, 1, 1, 1, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hEF, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hBE, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hAD, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'hDE, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
    add(1, 8'h5A, 1, 1, 1, 0, 8'h00, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 8'h5A, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
    add(1, 8'h01, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h02, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h03, 1, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h77, 0, 0, 0, 1, 8'h03, 0, 0);
    add(1, 8'h77, 0, 0, 0, 1, 8'h03, 0, 0);
    add(1, 8'h77, 0, 0, 0, 1, 8'h03, 0, 0);
    add(1, 8'h77, 0, 1, 0, 1, 8'h03, 0, 0);
    add(1, 8'h77, 0, 1, 0, 1, 8'h02, 0, 0);
    add(1, 8'h77, 1, 1, 0, 1, 8'h01, 1, 0);
    add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h01, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h02, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h03, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h04, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h05, 0, 0, 1, 0, 8'h00, 0, 0);
    add(1, 8'h06, 1, 0, 1, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'h04, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'h03, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'h02, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'h01, 1, 1);
    add(1, 8'hAA, 1, 0, 1, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 8'hAA, 1, 0);
    add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0);
    foreach (tab[i]) cycle(tab[i], 1'b1, acc, d);

    // Reset after two of four bytes have drained
    step(1, 8'hC1, 0, 1);
    step(1, 8'hC2, 0, 1);
    step(1, 8'hC3, 0, 1);
    step(1, 8'hC4, 1, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    got.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {7'd0, m_if.valid}, 8'd0);
    chk("arst_s_ready", {7'd0, s_if.ready}, 8'd1);
    chk("arst_m_data", m_if.data, 8'h00);
    mdl_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 1, 1);
    repeat (3) step(0, 8'h00, 0, 1);
    chk_got("post_rst", '{8'h22, 8'h11});

    // Back-to-back strings with a producer that holds valid high
    src_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    src_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      bit acc_in;
      acc_in = !mdl_drain && (idx < 5);
      if (idx < 5) step(1, src_d[idx], src_l[idx], 1);
      else         step(0, 8'h00, 0, 1);
      if (acc_in) idx++;
    end
    chk("b2b_consumed", 8'(idx), 8'd5);
    chk_got("b2b", '{8'h02, 8'h01, 8'h05, 8'h04, 8'h03});

    // Randomised traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    got.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
